// File: rtl/sha3_round_iterator.sv
// sha3_round_iterator: drives one 1600-bit Keccak state through an external iterable
// round core, one round per issue, always waiting for the core's ogood before continuing.
// Lane packing: each 320-bit lane port carries one row y of the state (isa = row 0 ...
// ise = row 4), with lane x at bits [64*x +: 64].
// FIRST_ROUND + ROUNDS must not exceed 24.
// Optional build macro SHA3_ROUND_ITERATOR_CHECK_EN adds a sticky oerr flag that is set
// whenever the core reports a round index different from the one issued.
module sha3_round_iterator #(
    parameter int unsigned ROUNDS      = 24,
    parameter int unsigned FIRST_ROUND = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [319:0] isa,
    input  logic [319:0] isb,
    input  logic [319:0] isc,
    input  logic [319:0] isd,
    input  logic [319:0] ise,
    input  logic         istart,
    output logic         iready,
    output logic [319:0] cra,
    output logic [319:0] crb,
    output logic [319:0] crc,
    output logic [319:0] crd,
    output logic [319:0] cre,
    output logic [4:0]   cround,
    output logic         csample,
    input  logic [319:0] cra_i,
    input  logic [319:0] crb_i,
    input  logic [319:0] crc_i,
    input  logic [319:0] crd_i,
    input  logic [319:0] cre_i,
    input  logic [4:0]   cround_i,
    input  logic         cgood_i,
    output logic [319:0] osa,
    output logic [319:0] osb,
    output logic [319:0] osc,
    output logic [319:0] osd,
    output logic [319:0] ose,
    output logic         ovalid,
    input  logic         oack
`ifdef SHA3_ROUND_ITERATOR_CHECK_EN
    ,
    output logic         oerr
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    localparam logic [4:0] FirstIdx  = 5'(FIRST_ROUND);
    localparam logic [4:0] LastCount = 5'(ROUNDS - 1);

    state_e     state_q;
    logic [4:0] count_q;

`ifndef SHA3_ROUND_ITERATOR_CHECK_EN
    // Round index echo from the core is only needed by the checker.
    logic unused_cround;
    assign unused_cround = ^cround_i;
`endif

    // Job sequencer: all outputs are registered and change only on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            iready  <= 1'b1;
            csample <= 1'b0;
            ovalid  <= 1'b0;
            cround  <= '0;
            cra     <= '0;
            crb     <= '0;
            crc     <= '0;
            crd     <= '0;
            cre     <= '0;
            osa     <= '0;
            osb     <= '0;
            osc     <= '0;
            osd     <= '0;
            ose     <= '0;
`ifdef SHA3_ROUND_ITERATOR_CHECK_EN
            oerr    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (istart) begin
                        cra     <= isa;
                        crb     <= isb;
                        crc     <= isc;
                        crd     <= isd;
                        cre     <= ise;
                        cround  <= FirstIdx;
                        count_q <= '0;
                        iready  <= 1'b0;
                        csample <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    csample <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cgood_i) begin
                        count_q <= count_q + 5'd1;
`ifdef SHA3_ROUND_ITERATOR_CHECK_EN
                        if (cround_i != cround) begin
                            oerr <= 1'b1;
                        end
`endif
                        if (count_q == LastCount) begin
                            osa     <= cra_i;
                            osb     <= crb_i;
                            osc     <= crc_i;
                            osd     <= crd_i;
                            ose     <= cre_i;
                            ovalid  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cra     <= cra_i;
                            crb     <= crb_i;
                            crc     <= crc_i;
                            crd     <= crd_i;
                            cre     <= cre_i;
                            cround  <= cround + 5'd1;
                            csample <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                end
                StDone: begin
                    if (oack) begin
                        ovalid  <= 1'b0;
                        iready  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/sha3_round_iterator.md
Name: sha3_round_iterator

Overview:
- Sequencer placed directly upstream of the iterable SHA3 round core. It also consumes the core's output.
- Accepts one 1600-bit Keccak state, issues it to the core with round_index = FIRST_ROUND, and waits for the core's ogood.
- Each returned state is fed back with the next round index until ROUNDS rounds are done, then the final state is held for a downstream consumer.
- The core's latency is not fixed; the iterator always waits for ogood and never counts cycles.

Parameters:
- ROUNDS, 24, number of rounds applied per job (1..24).
- FIRST_ROUND, 0, round index of the first issued round; FIRST_ROUND+ROUNDS must be ≤ 24.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- isa/isb/isc/isd/ise  in  64 x5 each  job state lanes
- istart  in  1  job valid; accepted only when iready=1
- iready  out  1  high in IDLE only
- cra/crb/crc/crd/cre  out  64 x5 each  state driven to core inputs
- cround  out  5  round_index to core
- csample  out  1  one-cycle sample pulse to core
- cra_i/crb_i/crc_i/crd_i/cre_i  in  64 x5 each  core output lanes
- cround_i  in  5  core oround
- cgood_i  in  1  core ogood
- osa/osb/osc/osd/ose  out  64 x5 each  final state
- ovalid  out  1  final state valid (level)
- oack  in  1  consumer accepts final state

Behaviour:
- Reset:
  - state → IDLE; iready=1, csample=0, ovalid=0, cround=0.
  - Lane outputs (c*, o*) reset to 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On istart & iready at cycle T: latch input lanes into the c* registers, set cround=FIRST_ROUND and count=0, go to ISSUE.
- ISSUE:
  - csample=1 for exactly one cycle (T+1), then go to WAIT.
  - c* lanes and cround stay stable from the issue cycle until the next reload.
- WAIT, on cgood_i=1:
  - Increment count.
  - If count+1 == ROUNDS: copy cra_i.. into o*, go to DONE.
  - Otherwise: copy cra_i.. into c*, set cround = cround+1, go to ISSUE. The next csample is exactly 1 cycle after cgood_i.
- Latency: a job with core latency L completes in 1 + ROUNDS·(L+1) cycles from istart to ovalid rising.
- DONE:
  - ovalid=1 and o* held stable until oack=1.
  - On oack, go to IDLE; iready rises the cycle after oack.
- istart while iready=0 is ignored; no queuing.
- cgood_i in IDLE, ISSUE or DONE is ignored. This covers stale core output after reset or spurious pulses.
- cround never exceeds FIRST_ROUND+ROUNDS-1; no wrap.
- ROUNDS=1: the first cgood_i goes directly to DONE.
- rst mid-job: abandon immediately, go to IDLE. The core has no reset and may still emit ogood; that pulse is discarded.
- rst has priority over every other input in the same cycle.
- oack in the same cycle that DONE is entered is not seen; oack is sampled only while ovalid=1.

Optional Feature:
- Macro: SHA3_ROUND_ITERATOR_CHECK_EN
- Defined:
  - Adds output port oerr (1 bit, resets 0).
  - On each accepted cgood_i in WAIT, compare cround_i with the issued cround. On mismatch, oerr is set sticky and cleared only by rst.
  - The job continues regardless of a mismatch.
- Undefined: no oerr port and no comparator; cround_i is unused.

Test Plan:
- Reset, then one job with an all-zero state, ROUNDS=24, model core latency L=3 → 24 csample pulses, cround 0..23. ovalid rises 97 cycles after istart; o* equals the Keccak-f[1600](0) lanes (osa[0]=64'hF1258F7940E1DDE7).
- istart pulsed while in WAIT or DONE → ignored; o* unchanged; no extra csample.
- Spurious cgood_i injected in IDLE and in ISSUE → no state change; round count still 24.
- rst asserted after the 10th cgood_i; the core later emits a stale ogood → iterator stays in IDLE with ovalid=0. A new job then completes correctly.
- ROUNDS=1, FIRST_ROUND=23 → single csample with cround=23; DONE after the first cgood_i. Holding oack low for 20 cycles keeps o* stable; oack=1 gives iready=1 next cycle.
- SHA3_ROUND_ITERATOR_CHECK_EN defined, model returns cround_i=5 when 4 was issued → oerr=1 from the next cycle, stays 1 after job completion, cleared by rst.
